// File: rtl/sample_serializer_pkg.sv
// sample_serializer_pkg: shared FSM state encoding and serial line levels for sample_serializer
package sample_serializer_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
  localparam logic TX_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: DEPTH x WIDTH FWFT FIFO; ports clk, rst, push, pop, data in, head out, full, empty, level
module sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  // a full FIFO still accepts a push when the same edge frees a slot
  assign do_push = push && (!full || do_pop);
  assign full = level == FULL_LVL;
  assign empty = level == '0;
  assign head = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= data;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      level <= level + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
endmodule

// File: rtl/sample_serializer.sv
// sample_serializer: FIFO-buffered UART-style sample serializer; ports clk, rst, in_data, in_dr -> tx, busy, overrun, fifo_level; SAMPLE_SERIALIZER_PARITY_EN adds an even-parity bit
module sample_serializer
  import sample_serializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_dr,
  output logic                     tx,
  output logic                     busy,
  output logic                     overrun,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [IW-1:0] bit_cnt, bit_n;
  logic [WIDTH-1:0] shift, shift_n, head;
  logic tx_n, pop, full, empty, baud_end, bit_end;
`ifdef SAMPLE_SERIALIZER_PARITY_EN
  logic par;
  always_ff @(posedge clk)
    if (pop) par <= ^head;
`endif
  sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(in_dr), .pop(pop), .data(in_data),
    .head(head), .full(full), .empty(empty), .level(fifo_level)
  );
  assign baud_end = baud == BW'(CLKS_PER_BIT - 1);
  assign bit_end = bit_cnt == IW'(WIDTH - 1);
  assign busy = state != IDLE || fifo_level != '0;
  always_comb begin
    state_n = state;
    baud_n = (state == IDLE || baud_end) ? '0 : baud + 1'b1;
    bit_n = bit_cnt;
    shift_n = shift;
    pop = 1'b0;
    case (state)
      IDLE:
        if (!empty) begin
          pop = 1'b1;
          shift_n = head;
          state_n = START;
        end
      START:
        if (baud_end) begin
          bit_n = '0;
          state_n = DATA;
        end
      DATA:
        if (baud_end) begin
          shift_n = shift >> 1;
          bit_n = bit_end ? '0 : bit_cnt + 1'b1;
`ifdef SAMPLE_SERIALIZER_PARITY_EN
          if (bit_end) state_n = PARITY;
`else
          if (bit_end) state_n = STOP;
`endif
        end
      PARITY:
        if (baud_end) state_n = STOP;
      STOP:
        // chain straight into the next frame when a word is waiting
        if (baud_end) begin
          pop = !empty;
          shift_n = empty ? shift : head;
          state_n = empty ? IDLE : START;
        end
      default: state_n = IDLE;
    endcase
    // tx is registered from the next state, so the line changes with the state
`ifdef SAMPLE_SERIALIZER_PARITY_EN
    tx_n = state_n == START ? START_BIT : state_n == DATA ? shift_n[0] :
           state_n == PARITY ? par_next(pop, head, par) : state_n == STOP ? STOP_BIT : TX_IDLE;
`else
    tx_n = state_n == START ? START_BIT : state_n == DATA ? shift_n[0] :
           state_n == STOP ? STOP_BIT : TX_IDLE;
`endif
  end
`ifdef SAMPLE_SERIALIZER_PARITY_EN
  function automatic logic par_next(logic ld, logic [WIDTH-1:0] w, logic p);
    return ld ? ^w : p;
  endfunction
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      shift <= '0;
      tx <= TX_IDLE;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_cnt <= bit_n;
      shift <= shift_n;
      tx <= tx_n;
      overrun <= overrun | (in_dr & full & ~pop);
    end
endmodule

// File: tb/tb_sample_serializer.sv
// tb_sample_serializer: randomized and directed bench comparing sample_serializer against a waveform-queue model
module tb_sample_serializer;
  localparam int W = 8;
  localparam int C = 4;
  localparam int D = 4;
`ifdef SAMPLE_SERIALIZER_PARITY_EN
  localparam int FL = (W + 3) * C;
`else
  localparam int FL = (W + 2) * C;
`endif
  logic clk = 0, rst = 1, in_dr = 0;
  logic [W-1:0] in_data = '0;
  logic tx, busy, overrun;
  logic [$clog2(D):0] fifo_level;
  int errors = 0, checks = 0;
  bit live = 0;
  bit m_q[$];
  logic [W-1:0] m_fifo[$];
  bit m_ovr;
  always #5 clk = ~clk;
  sample_serializer #(.WIDTH(W), .CLKS_PER_BIT(C), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_dr(in_dr),
    .tx(tx), .busy(busy), .overrun(overrun), .fifo_level(fifo_level)
  );
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction
  // the whole line waveform of one frame, one entry per clock cycle
  function automatic void load(logic [W-1:0] w);
    m_q.delete();
    repeat (C) m_q.push_back(1'b0);
    for (int i = 0; i < W; i++) repeat (C) m_q.push_back(w[i]);
`ifdef SAMPLE_SERIALIZER_PARITY_EN
    repeat (C) m_q.push_back(^w);
`endif
    repeat (C) m_q.push_back(1'b1);
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_fifo.delete();
      m_ovr = 0;
      live = 1;
    end else begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      if (m_q.size() == 0 && m_fifo.size() > 0) load(m_fifo.pop_front());
      if (in_dr) begin
        if (m_fifo.size() < D) m_fifo.push_back(in_data);
        else m_ovr = 1;
      end
    end
  end
  always @(negedge clk)
    if (live) begin
      chk("tx", tx, m_q.size() > 0 ? m_q[0] : 1'b1);
      chk("busy", busy, (m_q.size() > 0 || m_fifo.size() > 0) ? 1 : 0);
      chk("overrun", overrun, m_ovr);
      chk("fifo_level", fifo_level, m_fifo.size());
    end
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic strobe(logic [W-1:0] d);
    in_dr = 1;
    in_data = d;
    tick();
    in_dr = 0;
  endtask
  task automatic wait_idle();
    int k = 0;
    while (busy && k < 2000) begin
      tick();
      k++;
    end
    chk("idle_timeout", busy, 0);
  endtask
  initial begin
    logic [8:0] fr;
    tick(2);
    rst = 0;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_lvl", fifo_level, 0);
    tick(50);
    chk("quiet_busy", busy, 0);
    fr = {8'hA5, 1'b0};
    strobe(8'hA5);
    chk("a5_lvl", fifo_level, 1);
    chk("a5_pre", tx, 1);
    tick();
    for (int i = 0; i < 9; i++) begin
      chk("a5_bit_first", tx, fr[i]);
      tick(C - 1);
      chk("a5_bit_last", tx, fr[i]);
      tick();
    end
    chk("a5_tail_tx", tx, FL == (W + 2) * C ? 1 : 0);
    tick(FL - 9 * C - 1);
    chk("a5_busy_end", busy, 1);
    tick();
    chk("a5_busy_drop", busy, 0);
    in_dr = 1;
    for (int i = 1; i <= 3; i++) begin
      in_data = W'(i);
      tick();
    end
    in_dr = 0;
    chk("b2b_lvl", fifo_level, 2);
    wait_idle();
    in_dr = 1;
    for (int i = 0; i < 6; i++) begin
      in_data = W'(8'h10 + i);
      tick();
    end
    in_dr = 0;
    chk("ovf_lvl", fifo_level, 4);
    chk("ovf_flag", overrun, 1);
    wait_idle();
    chk("ovf_sticky", overrun, 1);
    strobe(8'hFF);
    strobe(8'hAA);
    tick(10);
    rst = 1;
    tick();
    rst = 0;
    chk("abort_tx", tx, 1);
    chk("abort_lvl", fifo_level, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ovr", overrun, 0);
    strobe(8'h3C);
    wait_idle();
`ifdef SAMPLE_SERIALIZER_PARITY_EN
    strobe(8'h07);
    tick(1 + 9 * C);
    chk("par07", tx, 1);
    tick(C);
    chk("par07_stop", tx, 1);
    tick(C);
    chk("par07_len", busy, 0);
    strobe(8'h03);
    tick(1 + 9 * C);
    chk("par03", tx, 0);
    tick(2 * C);
    chk("par03_len", busy, 0);
`endif
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(0, 499) == 0;
      in_dr = $urandom_range(0, 99) < 9;
      in_data = W'($urandom);
      tick();
    end
    rst = 0;
    in_dr = 0;
    wait_idle();
    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
